// File: rtl/reg_write_arbiter.sv
// Single-write-port arbiter: NREQ writers share one WIDTH-bit register via an IDLE/WRITE/DONE FSM.
// Optional build macro REG_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module reg_write_arbiter #(
    parameter int               NREQ      = 4,
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*WIDTH-1:0]     wdata,
    output logic [NREQ-1:0]           ack,
    output logic [WIDTH-1:0]          out,
    output logic [$clog2(NREQ)-1:0]   owner,
    output logic                      busy,
    output logic [7:0]                write_count
);
    localparam int IDX_W = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   grant_reg, grant_next;
    logic [NREQ-1:0]    req_q_reg;
    logic [WIDTH-1:0]   out_reg, out_next;
    logic [NREQ-1:0]    ack_reg, ack_next;
    logic [IDX_W-1:0]   owner_reg, owner_next;
    logic               busy_reg, busy_next;
    logic [7:0]         count_reg, count_next;
    logic [IDX_W-1:0]   winner;
    logic [WIDTH-1:0]   wdata_arr [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign wdata_arr[gi] = wdata[gi*WIDTH +: WIDTH];
        end
    endgenerate

`ifdef REG_ARB_FIXED_PRIO_EN
    // Lowest set index wins; scanning downward leaves the lowest one last.
    always_comb begin
        winner = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_q_reg[k]) winner = IDX_W'(k);
        end
    end
`else
    logic [IDX_W-1:0] rr_ptr_reg, rr_ptr_next;
    int               rr_idx;
    logic             rr_found;

    // Search begins one past the last granted requester and wraps modulo NREQ.
    always_comb begin
        winner   = '0;
        rr_idx   = 0;
        rr_found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            rr_idx = (int'(rr_ptr_reg) + k) % NREQ;
            if (!rr_found && req_q_reg[rr_idx]) begin
                winner   = IDX_W'(rr_idx);
                rr_found = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        out_next   = out_reg;
        ack_next   = '0;
        owner_next = owner_reg;
        count_next = count_reg;
`ifndef REG_ARB_FIXED_PRIO_EN
        rr_ptr_next = rr_ptr_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (|req_q_reg) begin
                    grant_next = winner;
                    state_next = WRITE;
                end
            end
            WRITE: begin
                // Live req is checked here so a writer that drops out is not written.
                if (req[grant_reg]) begin
                    out_next           = wdata_arr[grant_reg];
                    ack_next[grant_reg] = 1'b1;
                    owner_next         = grant_reg;
                    count_next         = count_reg + 8'd1;
`ifndef REG_ARB_FIXED_PRIO_EN
                    rr_ptr_next        = grant_reg;
`endif
                    state_next         = DONE;
                end else begin
                    state_next = IDLE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            grant_reg  <= '0;
            req_q_reg  <= '0;
            out_reg    <= RESET_VAL;
            ack_reg    <= '0;
            owner_reg  <= '0;
            busy_reg   <= 1'b0;
            count_reg  <= '0;
`ifndef REG_ARB_FIXED_PRIO_EN
            rr_ptr_reg <= IDX_W'(NREQ - 1);
`endif
        end else begin
            state_reg  <= state_next;
            grant_reg  <= grant_next;
            req_q_reg  <= req;
            out_reg    <= out_next;
            ack_reg    <= ack_next;
            owner_reg  <= owner_next;
            busy_reg   <= busy_next;
            count_reg  <= count_next;
`ifndef REG_ARB_FIXED_PRIO_EN
            rr_ptr_reg <= rr_ptr_next;
`endif
        end
    end

    assign ack         = ack_reg;
    assign out         = out_reg;
    assign owner       = owner_reg;
    assign busy        = busy_reg;
    assign write_count = count_reg;
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: vector table of single writes plus multi-cycle sequences.
module tb_reg_write_arbiter;
    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] wdata;
    logic [NREQ-1:0]       ack;
    logic [WIDTH-1:0]      dout;
    logic [1:0]            owner;
    logic                  busy;
    logic [7:0]            write_count;

    int n_cmp = 0;
    int n_err = 0;

    reg_write_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .RESET_VAL(8'h00)) dut (
        .clk(clk), .reset(reset), .req(req), .wdata(wdata), .ack(ack),
        .out(dout), .owner(owner), .busy(busy), .write_count(write_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         idx;
        logic [7:0] data;
        logic [7:0] exp_out;
        logic [3:0] exp_ack;
        logic [1:0] exp_owner;
        logic [7:0] exp_count;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Raise one request from idle and check the full IDLE->WRITE->DONE->IDLE timeline.
    task automatic single_write(input int idx, input logic [7:0] data, input logic [7:0] exp_out,
                                input logic [3:0] exp_ack, input logic [1:0] exp_owner,
                                input logic [7:0] exp_count);
        req = '0;
        req[idx] = 1'b1;
        wdata[idx*WIDTH +: WIDTH] = data;
        step();
        check("sw_busy_n", 32'(busy), 32'd0);
        step();
        check("sw_busy_n1", 32'(busy), 32'd1);
        check("sw_ack_n1", 32'(ack), 32'd0);
        step();
        check("sw_out", 32'(dout), 32'(exp_out));
        check("sw_ack", 32'(ack), 32'(exp_ack));
        check("sw_owner", 32'(owner), 32'(exp_owner));
        check("sw_count", 32'(write_count), 32'(exp_count));
        $display("write req=%0d data=%02h -> out=%02h ack=%04b count=%0d", idx, data, dout, ack, write_count);
        req = '0;
        step();
        check("sw_ack_clr", 32'(ack), 32'd0);
        check("sw_busy_clr", 32'(busy), 32'd0);
    endtask

    initial begin
        vec_t       vecs [4];
        logic [3:0] exp_ack3 [4];
        logic [7:0] exp_out3 [4];
        int         exp_g [4];
        int         n;
        int         last_cyc;

        vecs[0] = '{idx: 1, data: 8'hAE, exp_out: 8'hAE, exp_ack: 4'b0010, exp_owner: 2'd1, exp_count: 8'd1};
        vecs[1] = '{idx: 0, data: 8'h81, exp_out: 8'h81, exp_ack: 4'b0001, exp_owner: 2'd0, exp_count: 8'd2};
        vecs[2] = '{idx: 2, data: 8'hC3, exp_out: 8'hC3, exp_ack: 4'b0100, exp_owner: 2'd2, exp_count: 8'd3};
        vecs[3] = '{idx: 3, data: 8'h3C, exp_out: 8'h3C, exp_ack: 4'b1000, exp_owner: 2'd3, exp_count: 8'd4};
        exp_ack3 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        exp_out3 = '{8'h11, 8'h22, 8'h33, 8'h44};
`ifdef REG_ARB_FIXED_PRIO_EN
        exp_g = '{0, 0, 0, 0};
`else
        exp_g = '{0, 3, 0, 3};
`endif

        // Reset state, then release with no requests.
        reset = 1'b1;
        req   = '0;
        wdata = '0;
        repeat (3) step();
        check("rst_out", 32'(dout), 32'h00);
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_owner", 32'(owner), 32'd0);
        check("rst_count", 32'(write_count), 32'd0);
        reset = 1'b0;
        step();
        step();
        check("rel_out", 32'(dout), 32'h00);
        check("rel_busy", 32'(busy), 32'd0);
        check("rel_count", 32'(write_count), 32'd0);

        // Vector table: single writers in turn.
        for (int i = 0; i < 4; i++)
            single_write(vecs[i].idx, vecs[i].data, vecs[i].exp_out, vecs[i].exp_ack,
                         vecs[i].exp_owner, vecs[i].exp_count);

        // All four request at once; each drops on its own ack.
        req   = 4'b1111;
        wdata = {8'h44, 8'h33, 8'h22, 8'h11};
        n = 0;
        last_cyc = 0;
        for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
            step();
            if (ack != '0) begin
                check("t3_onehot", 32'($countones(ack)), 32'd1);
                check("t3_ack", 32'(ack), 32'(exp_ack3[n]));
                check("t3_out", 32'(dout), 32'(exp_out3[n]));
                if (n > 0) check("t3_spacing", 32'(cyc - last_cyc), 32'd3);
                $display("write ack=%04b out=%02h cycle=%0d", ack, dout, cyc);
                last_cyc = cyc;
                req = req & ~ack;
                n++;
            end
        end
        check("t3_acks_seen", 32'(n), 32'd4);
        check("t3_count", 32'(write_count), 32'd8);
        step();

        // Abort: requester 2 drops out during WRITE.
        req = 4'b0100;
        wdata[2*WIDTH +: WIDTH] = 8'h77;
        step();
        step();
        check("t4_busy_write", 32'(busy), 32'd1);
        req = '0;
        step();
        check("t4_ack", 32'(ack), 32'd0);
        check("t4_out", 32'(dout), 32'h44);
        check("t4_count", 32'(write_count), 32'd8);
        check("t4_idle", 32'(busy), 32'd0);
        $display("abort req=2 -> out=%02h count=%0d", dout, write_count);
        step();
        single_write(3, 8'h99, 8'h99, 4'b1000, 2'd3, 8'd9);

        // Reset pulsed while in WRITE.
        req = 4'b0001;
        wdata[0 +: WIDTH] = 8'h5A;
        step();
        step();
        check("t5_busy_write", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("t5_rst_out", 32'(dout), 32'h00);
        check("t5_rst_ack", 32'(ack), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        step();
        reset = 1'b0;
        n = 0;
        for (int cyc = 0; cyc < 10 && n == 0; cyc++) begin
            step();
            if (ack != '0) begin
                check("t5_ack", 32'(ack), 32'b0001);
                check("t5_out", 32'(dout), 32'h5A);
                check("t5_count", 32'(write_count), 32'd1);
                $display("write after reset ack=%04b out=%02h", ack, dout);
                n = 1;
            end
        end
        check("t5_ack_seen", 32'(n), 32'd1);
        req = '0;
        step();

        // Requesters 0 and 3 held high continuously.
        reset = 1'b1;
        step();
        reset = 1'b0;
        req   = 4'b1001;
        wdata = {8'hD3, 8'h00, 8'h00, 8'hA0};
        n = 0;
        for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
            step();
            if (ack != '0) begin
                check("t6_grant", 32'(ack), 32'(4'b0001 << exp_g[n]));
                check("t6_out", 32'(dout), (exp_g[n] == 0) ? 32'hA0 : 32'hD3);
                $display("write held ack=%04b out=%02h", ack, dout);
                n++;
            end
        end
        check("t6_acks_seen", 32'(n), 32'd4);
        check("t6_count", 32'(write_count), 32'd4);
        req = '0;
        step();
        step();

        // write_count wrap FF -> 00 with one writer held high.
        req = 4'b0010;
        wdata[1*WIDTH +: WIDTH] = 8'hE7;
        n = 0;
        for (int cyc = 0; cyc < 900 && n < 252; cyc++) begin
            step();
            if (ack != '0) begin
                n++;
                if (n == 251) check("t7_count_ff", 32'(write_count), 32'hFF);
                if (n == 252) check("t7_count_wrap", 32'(write_count), 32'h00);
            end
        end
        check("t7_acks_seen", 32'(n), 32'd252);
        $display("wrap run: %0d writes, count=%02h", n, write_count);
        req = '0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
Shares one WIDTH-bit storage register between NREQ independent writers.
- Each writer raises a request with its write data.
- The block arbitrates, writes the winner's data into the register and returns a one-cycle acknowledge.
- Sits in front of the 8-bit register datapath and is its single write port. Downstream logic reads `out`.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 8, register and data width in bits
RESET_VAL, 8'h00, value loaded into `out` on reset

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
req  input  NREQ  per-requester write request, level
wdata  input  NREQ*WIDTH  packed write data; requester i uses bits [i*WIDTH +: WIDTH]
ack  output  NREQ  one-hot write-complete pulse, one cycle
out  output  WIDTH  register contents
owner  output  $clog2(NREQ)  index of last granted requester
busy  output  1  high whenever FSM is not IDLE
write_count  output  8  completed writes, wraps FF->00

Behaviour:
- One clock. Reset is asynchronous and active-high.
- While reset is high, all state is forced immediately:
  - out=RESET_VAL, ack=0, busy=0, owner=0, write_count=0
  - state=IDLE, rr_ptr=NREQ-1, so requester 0 has top priority after reset.
- FSM states: IDLE, WRITE, DONE. All outputs are registered.
- IDLE:
  - If any req bit is high, pick a winner and set grant_idx<=winner, state<=WRITE.
  - Otherwise stay in IDLE.
  - busy=0 only in this state.
- Arbitration is round-robin: search starts at rr_ptr+1 mod NREQ and takes the first set req bit.
- WRITE, when req[grant_idx]=1:
  - out<=wdata[grant_idx], ack[grant_idx]<=1, owner<=grant_idx
  - rr_ptr<=grant_idx, write_count<=write_count+1, state<=DONE
- WRITE, when req[grant_idx]=0 (requester aborted):
  - No write, no ack. out, owner, rr_ptr and write_count are unchanged.
  - state<=IDLE.
- DONE: ack is high for exactly this cycle. On the next edge ack<=0 and state<=IDLE.
- Latency: req first sampled high at edge N in IDLE gives out and ack updated at edge N+2. ack is low again after edge N+3.
- Throughput: at most one write per 3 cycles.
- Requester contract:
  - Hold req and wdata stable until ack is seen.
  - Deassert req in the ack cycle.
  - If req is still high when the FSM reaches IDLE, it is treated as a new request and arbitrated again.
- Requests arriving in WRITE or DONE are not lost. They are evaluated in the next IDLE.
- wdata is sampled only on the WRITE edge; changes at any other time have no effect.
- write_count wraps 8'hFF -> 8'h00 without a flag.
- Reset mid-operation: any pending ack is dropped immediately and out returns to RESET_VAL.

Optional Feature:
REG_ARB_FIXED_PRIO_EN
- Defined: arbitration is fixed priority; the lowest set req index always wins. rr_ptr is neither kept nor used, and starvation of higher indices is permitted.
- Undefined (default): round-robin as above.
- All other timing is identical in both builds.

Test Plan:
1. Reset with clk running and req=0 -> out=00, ack=0000, busy=0, owner=0, write_count=0. Deassert reset -> all unchanged.
2. req[1]=1 with wdata1=AE, held until ack -> busy=1 from edge N+1, out=AE and ack=0010 at edge N+2 for one cycle, owner=1, write_count=1.
3. req=1111 with data 11/22/33/44, each deasserting on its own ack -> ack order 0,1,2,3 at 3-cycle spacing, out sequence 11,22,33,44, write_count=4, never more than one ack bit high.
4. Abort: req[2]=1 with wdata2=77, dropped in the WRITE cycle -> out keeps previous value, no ack, write_count unchanged, FSM back to IDLE; next request from 3 wins.
5. reset pulsed while in WRITE with req[0]=1, wdata0=5A -> out=00 immediately, no ack, busy=0; after release the request completes normally with out=5A.
6. req[0] and req[3] held high continuously, each re-raised after ack:
   - Default build: grants alternate 0,3,0,3.
   - REG_ARB_FIXED_PRIO_EN build: grants 0,0,0, and requester 3 is never acked.
